// File: rtl/score_disp_pkg.sv
// score_disp_pkg: shared segment codes, scan-state encoding and anode patterns
// for score_display_mux and seg7_decoder. Segment codes are {g,f,e,d,c,b,a},
// active-low; anode patterns are active-low, one-cold.
package score_disp_pkg;
  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} scan_t;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_DIG0   = 4'b1110;
  localparam logic [3:0] AN_DIG1   = 4'b1101;
  localparam logic [3:0] AN_DIG2   = 4'b1011;
  localparam logic [3:0] AN_DIG3   = 4'b0111;
  localparam logic [3:0] AN_OFF    = 4'b1111;
  function automatic logic [3:0] anode(input scan_t s);
    return s == DIG0 ? AN_DIG0 : s == DIG1 ? AN_DIG1 : s == DIG2 ? AN_DIG2 : AN_DIG3;
  endfunction
  function automatic logic [3:0] tens(input logic [3:0] v);
    return {3'b000, v >= 4'd10};
  endfunction
  function automatic logic [3:0] ones(input logic [3:0] v);
    return v >= 4'd10 ? v - 4'd10 : v;
  endfunction
endpackage

// File: rtl/score_display_mux_if.sv
// score_display_mux_if: score/win/enable inputs and 7-segment outputs of the display mux.
// Signals: score_a, score_b (4b scores), win_a, win_b (win levels), en (display enable),
// an (4b anodes), seg (7b cathodes), dp (decimal point); master drives inputs, slave is the display.
interface score_display_mux_if;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic       win_a;
  logic       win_b;
  logic       en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  modport master (output score_a, score_b, win_a, win_b, en, input an, seg, dp);
  modport slave  (input score_a, score_b, win_a, win_b, en, output an, seg, dp);
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational BCD digit to active-low 7-segment code.
// Ports: digit (4b, 0..9), blank (force all segments off), seg (7b {g,f,e,d,c,b,a}).
module seg7_decoder
  import score_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (!blank)
      case (digit)
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
  end
endmodule

// File: rtl/score_display_mux.sv
// score_display_mux: samples two async 4-bit scores and win flags, shows them as
// two decimal digits each on a 4-digit multiplexed active-low 7-segment display,
// flashing the half of a player whose win flag is held.
// Ports: clk, rst (sync, active-low), bus (score_display_mux_if.slave).
// Option: define LEADING_ZERO_BLANK_EN to blank tens digits that are 0.
module score_display_mux
  import score_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int FLASH_DIV   = 25000000
) (
  input logic clk,
  input logic rst,
  score_display_mux_if.slave bus
);
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = FLASH_DIV > 1 ? $clog2(FLASH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FMAX = FW'(FLASH_DIV - 1);
  // capture vector layout: {win_b, win_a, score_b, score_a}
  logic [9:0] s1, s2, s3, held;
  logic [PW-1:0] pcnt;
  logic tick;
  scan_t state, state_nxt;
  logic [3:0] frame_a, frame_b;
  logic [FW-1:0] fcnt;
  logic phase;
  logic [3:0] digit;
  logic flash_blank, blank, dp_nxt;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  // held only follows the chain once two consecutive samples agree on all bits,
  // so a score caught mid-transition never reaches the display
  always_ff @(posedge clk)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      held <= '0;
    end else begin
      s1 <= {bus.win_b, bus.win_a, bus.score_b, bus.score_a};
      s2 <= s1;
      s3 <= s2;
      if (s2 == s3) held <= s2;
    end
  assign tick = pcnt == PMAX;
  always_ff @(posedge clk)
    if (!rst) pcnt <= '0;
    else pcnt <= tick ? '0 : pcnt + 1'b1;
  always_ff @(posedge clk)
    if (!rst) state <= DIG0;
    else state <= state_nxt;
  always_comb state_nxt = tick ? scan_t'(state + 2'd1) : state;
  // frame is latched only at the DIG3->DIG0 wrap so a frame never mixes values
  always_ff @(posedge clk)
    if (!rst) {frame_b, frame_a} <= '0;
    else if (tick && state == DIG3) {frame_b, frame_a} <= held[7:0];
  always_ff @(posedge clk)
    if (!rst || !(held[8] | held[9])) begin
      fcnt <= '0;
      phase <= 1'b1;
    end else if (fcnt == FMAX) begin
      fcnt <= '0;
      phase <= ~phase;
    end else fcnt <= fcnt + 1'b1;
  // state[1] selects player A digits (DIG2/DIG3); state[0] selects tens digits
  always_comb begin
    digit = state == DIG3 ? tens(frame_a) : state == DIG2 ? ones(frame_a) :
            state == DIG1 ? tens(frame_b) : ones(frame_b);
    flash_blank = !phase && ((held[8] && state[1]) || (held[9] && !state[1]));
`ifdef LEADING_ZERO_BLANK_EN
    blank = flash_blank || (state[0] && digit == 4'd0);
`else
    blank = flash_blank;
`endif
    an_nxt = bus.en ? anode(state) : AN_OFF;
    dp_nxt = !(bus.en && state == DIG2 && !flash_blank);
  end
  seg7_decoder u_dec (.digit(digit), .blank(blank), .seg(seg_nxt));
  always_ff @(posedge clk)
    if (!rst) begin
      bus.an <= AN_OFF;
      bus.seg <= SEG_BLANK;
      bus.dp <= 1'b1;
    end else begin
      bus.an <= an_nxt;
      bus.seg <= seg_nxt;
      bus.dp <= dp_nxt;
    end
endmodule

// File: doc/score_display_mux.md
Name: score_display_mux

Overview:
Downstream consumer of the two per-player modulo-N score counters. Safely samples their 4-bit Q outputs, which change on Score_update edges asynchronous to clk. Converts each score to two decimal digits and time-multiplexes them onto the board's 4-digit active-low 7-segment display. Flashes a player's half of the display while that player's win flag is asserted.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot (50 MHz gives 1 kHz per digit)
FLASH_DIV, 25000000, clk cycles per flash half-period

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
score_a  in  4  player A counter Q, binary 0..15, asynchronous to clk
score_b  in  4  player B counter Q, binary 0..15, asynchronous to clk
win_a  in  1  player A win level, asynchronous
win_b  in  1  player B win level, asynchronous
en  in  1  display enable, synchronous
an  out  4  digit anodes, active-low, one-cold
seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low

Behaviour:
- Reset (rst=0 at clk edge) clears:
  - all sync flops, held and frame registers to 0
  - prescaler to 0; scan state to DIG0
  - flash counter to 0; flash_phase to 1 (visible)
- Outputs on reset: an=4'b1111, seg=7'b1111111, dp=1. Reset mid-frame takes effect on the next edge, no partial completion.
- Input capture (score_a, score_b, win_a, win_b, per bit):
  - chain s1<=in, s2<=s1, s3<=s2
  - held<=s2 only when s2==s3 (multi-bit stability filter)
  - a stable input change reaches held on the 4th clk edge
- Prescaler: counts 0..REFRESH_DIV-1 and wraps; tick=1 when count==REFRESH_DIV-1.
- Scan FSM: states DIG0->DIG1->DIG2->DIG3->DIG0, advancing on tick only.
- Frame latch: frame regs<=held on the tick that moves DIG3->DIG0. The displayed value never changes mid-frame.
- Digit map:
  - DIG3 = A tens, DIG2 = A ones, DIG1 = B tens, DIG0 = B ones
  - tens = (v>=10), ones = v-10 if v>=10 else v
  - dp=0 only in DIG2 (separator)
- Anodes: DIG0=1110, DIG1=1101, DIG2=1011, DIG3=0111.
- Decoder codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, BLANK=1111111.
- Outputs an/seg/dp are registered, one clk after the scan state or tick.
- Flash:
  - flash counter runs only while held win_a|win_b
  - on reaching FLASH_DIV-1 it wraps and toggles flash_phase
  - when neither win is held: counter=0, phase=1
  - phase=0 with win_a: DIG3/DIG2 show seg=BLANK, dp=1
  - phase=0 with win_b: DIG1/DIG0 blank; both wins blank all digits
- en=0: an=1111 and dp=1 from the next edge; scan, prescaler and capture keep running. en=1 resumes at the current scan state.
- Inputs >15 are unreachable; no special handling.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: a tens digit of 0 (DIG3 or DIG1) outputs seg=BLANK.
- Undefined: it outputs the code for 0 (1000000).
- Ones digits are never blanked by this feature.

Decomposition:
- Package score_disp_pkg holds:
  - segment code constants SEG_0..SEG_9 and SEG_BLANK
  - scan state encoding DIG0..DIG3
  - anode one-cold constants
- One sub-module: seg7_decoder (4-bit digit plus blank input -> 7-bit active-low seg), combinational, instantiated once on the muxed digit.

Test Plan:
Bench uses REFRESH_DIV=4, FLASH_DIV=8, clk period 10 ns.
1. rst=0 for 3 clk -> an=1111, seg=1111111, dp=1; release -> first tick 4 clk later, then an=1110 one clk after.
2. score_a=12, score_b=7 static for 2 frames -> second frame shows an=0111/seg=1111001, an=1011/seg=0100100/dp=0, an=1101/seg=1000000 (BLANK if macro defined), an=1110/seg=1111000.
3. score_b 7->8 while DIG1 active -> DIG0 still shows 1111000 this frame; next frame shows 0000000.
4. score_a toggled for 1 clk only (glitch, 5->6->5) -> held never takes 6; displayed remains 0010010.
5. win_a=1 held -> DIG3/DIG2 blank for 8 clk, visible for 8 clk, repeating; DIG1/DIG0 unaffected. win_a=0 -> phase=1 within 4 clk, digits steady.
6. en=0 mid-frame -> an=1111 next edge while scan advances; rst=0 mid-DIG2 -> next edge outputs reset values and state DIG0.
